main_controller: RTL and testbench

MAIN_CONTROLLER -- requirements
Module: main_controller

---
 rtl/main_controller.sv | 220 ++++++++++++++++++++++
 tb/tb_main_controller.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/main_controller.sv
// Multicycle RV32 subset control unit: sequences fetch, decode, memory,
// ALU and branch/jump steps, and drives datapath selects and write strobes.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// FETCH    | read instruction at PC, PC+4; waits for memory
// DECODE   | read registers, precompute PC+imm
// MEMADR   | form load/store address from rs1+imm
// MEMREAD  | read data memory at computed address; waits for memory
// MEMWB    | write load data to register file
// MEMWRITE | write data memory; strobe held until memory accepts
// EXECUTER | ALU op on rs1, rs2
// EXECUTEI | ALU op on rs1, imm
// ALUWB    | write ALU result to register file
// BEQ      | compare rs1/rs2; PC update when zero
// JAL      | PC <= PC+imm, link value prepared for ALUWB
// ERROR    | unknown opcode or state code; stays until reset
module main_controller #(
   parameter bit MEM_HANDSHAKE = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   input  logic       memReady,
   output logic       pcWrite,
   output logic       irWrite,
   output logic       regWrite,
   output logic       memWrite,
   output logic       adrSrc,
   output logic [1:0] resultSrc,
   output logic [1:0] aluSrcA,
   output logic [1:0] aluSrcB,
   output logic [1:0] immSrc,
   output logic [2:0] aluControl,
   output logic [3:0] state,
   output logic       illegal
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10,
      S_ERROR    = 4'd11
   } state_t;

   // Moore control word; the fetch/beq flags gate the few Mealy strobes.
   typedef struct packed {
      logic       adr_src;
      logic [1:0] result_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       reg_write;
      logic       mem_write;
      logic       pc_jal;
      logic       in_fetch;
      logic       in_beq;
      logic       err;
   } ctrl_t;

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_RTYP = 7'b0110011;
   localparam logic [6:0] OP_ITYP = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   state_t state_q;
   ctrl_t  ctrl_q;
   logic   mem_rdy;

   assign mem_rdy = MEM_HANDSHAKE ? memReady : 1'b1;

   function automatic ctrl_t decode_ctrl(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.alu_src_b  = 2'b10;
            c.result_src = 2'b10;
            c.in_fetch   = 1'b1;
         end
         S_DECODE: begin
            c.alu_src_a = 2'b01;
            c.alu_src_b = 2'b01;
         end
         S_MEMADR: begin
            c.alu_src_a = 2'b10;
            c.alu_src_b = 2'b01;
         end
         S_MEMREAD: c.adr_src = 1'b1;
         S_MEMWB: begin
            c.result_src = 2'b01;
            c.reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            c.adr_src   = 1'b1;
            c.mem_write = 1'b1;
         end
         S_EXECUTER: begin
            c.alu_src_a = 2'b10;
            c.alu_op    = 2'b10;
         end
         S_EXECUTEI: begin
            c.alu_src_a = 2'b10;
            c.alu_src_b = 2'b01;
            c.alu_op    = 2'b10;
         end
         S_ALUWB: c.reg_write = 1'b1;
         S_BEQ: begin
            c.alu_src_a = 2'b10;
            c.alu_op    = 2'b01;
            c.in_beq    = 1'b1;
         end
         S_JAL: begin
            c.alu_src_a = 2'b01;
            c.alu_src_b = 2'b10;
            c.pc_jal    = 1'b1;
         end
         default: c.err = 1'b1;
      endcase
      return c;
   endfunction

   function automatic state_t next_state(input state_t s, input logic [6:0] opc,
                                         input logic rdy);
      state_t n;
      n = S_ERROR;
      case (s)
         S_FETCH:    n = rdy ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opc)
               OP_LW, OP_SW: n = S_MEMADR;
               OP_RTYP:      n = S_EXECUTER;
               OP_ITYP:      n = S_EXECUTEI;
               OP_BEQ:       n = S_BEQ;
               OP_JAL:       n = S_JAL;
               default:      n = S_ERROR;
            endcase
         end
         S_MEMADR:   n = (opc == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  n = rdy ? S_MEMWB : S_MEMREAD;
         S_MEMWB:    n = S_FETCH;
         S_MEMWRITE: n = rdy ? S_FETCH : S_MEMWRITE;
         S_EXECUTER: n = S_ALUWB;
         S_EXECUTEI: n = S_ALUWB;
         S_ALUWB:    n = S_FETCH;
         S_BEQ:      n = S_FETCH;
         S_JAL:      n = S_ALUWB;
         default:    n = S_ERROR;
      endcase
      return n;
   endfunction

   // State register with the Moore control word registered for the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         ctrl_q  <= decode_ctrl(S_FETCH);
      end else begin
         state_q <= next_state(state_q, op, mem_rdy);
         ctrl_q  <= decode_ctrl(next_state(state_q, op, mem_rdy));
      end
   end

   // ALU operation from the internal aluOp and instruction fields.
   always_comb begin
      aluControl = 3'b000;
      case (ctrl_q.alu_op)
         2'b01: aluControl = 3'b001;
         2'b10: begin
            case (funct3)
               3'b000:  aluControl = (op[5] && funct7b5) ? 3'b001 : 3'b000;
               3'b010:  aluControl = 3'b101;
               3'b110:  aluControl = 3'b011;
               3'b111:  aluControl = 3'b010;
               default: aluControl = 3'b000;
            endcase
         end
         default: aluControl = 3'b000;
      endcase
   end

   // Immediate format follows the opcode in every state.
   always_comb begin
      case (op)
         OP_SW:   immSrc = 2'b01;
         OP_BEQ:  immSrc = 2'b10;
         OP_JAL:  immSrc = 2'b11;
         default: immSrc = 2'b00;
      endcase
   end

   // Strobes are killed combinationally while reset is asserted, so nothing
   // fires in the cycle reset is sampled, whatever state we came from.
   assign irWrite  = rst ? 1'b0 : (ctrl_q.in_fetch & mem_rdy);
   assign pcWrite  = rst ? 1'b0 : ((ctrl_q.in_fetch & mem_rdy) | ctrl_q.pc_jal |
                                   (ctrl_q.in_beq & zero));
   assign regWrite = rst ? 1'b0 : ctrl_q.reg_write;
   assign memWrite = rst ? 1'b0 : ctrl_q.mem_write;
   assign illegal  = rst ? 1'b0 : ctrl_q.err;

   assign adrSrc    = ctrl_q.adr_src;
   assign resultSrc = ctrl_q.result_src;
   assign aluSrcA   = ctrl_q.alu_src_a;
   assign aluSrcB   = ctrl_q.alu_src_b;
   assign state     = state_q;

endmodule

// File: tb/tb_main_controller.sv
// Directed bench for main_controller: handshake and no-handshake instances.
module tb_main_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;
   logic       memReady;

   logic       pcWrite, irWrite, regWrite, memWrite, adrSrc, illegal;
   logic [1:0] resultSrc, aluSrcA, aluSrcB, immSrc;
   logic [2:0] aluControl;
   logic [3:0] state;

   logic       pcWrite2, irWrite2, regWrite2, memWrite2, adrSrc2, illegal2;
   logic [1:0] resultSrc2, aluSrcA2, aluSrcB2, immSrc2;
   logic [2:0] aluControl2;
   logic [3:0] state2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   main_controller #(.MEM_HANDSHAKE(1'b1)) dut (
      .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .zero(zero), .memReady(memReady), .pcWrite(pcWrite), .irWrite(irWrite),
      .regWrite(regWrite), .memWrite(memWrite), .adrSrc(adrSrc),
      .resultSrc(resultSrc), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
      .immSrc(immSrc), .aluControl(aluControl), .state(state), .illegal(illegal)
   );

   main_controller #(.MEM_HANDSHAKE(1'b0)) dut_nohs (
      .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .zero(zero), .memReady(memReady), .pcWrite(pcWrite2), .irWrite(irWrite2),
      .regWrite(regWrite2), .memWrite(memWrite2), .adrSrc(adrSrc2),
      .resultSrc(resultSrc2), .aluSrcA(aluSrcA2), .aluSrcB(aluSrcB2),
      .immSrc(immSrc2), .aluControl(aluControl2), .state(state2),
      .illegal(illegal2)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // strobe bundle {pcWrite, irWrite, regWrite, memWrite}
   function automatic logic [3:0] strobes();
      return {pcWrite, irWrite, regWrite, memWrite};
   endfunction

   initial begin
      rst = 1'b1; op = 7'b0000011; funct3 = 3'b000; funct7b5 = 1'b0;
      zero = 1'b0; memReady = 1'b1;
      #1;
      chk("rst_strobes_pre", {12'h0, strobes()}, 16'h0);
      chk("rst_illegal_pre", {15'h0, illegal}, 16'h0);
      tick();
      chk("rst_state", {12'h0, state}, 16'h0);
      chk("rst_strobes", {12'h0, strobes()}, 16'h0);
      rst = 1'b0;
      #1;

      // lw: 0,1,2,3,4,0
      chk("lw_c1_state", {12'h0, state}, 16'h0);
      chk("lw_c1_strobes", {12'h0, strobes()}, 16'b1100);
      chk("lw_c1_sel", {8'h0, resultSrc, aluSrcA, aluSrcB, 1'b0, adrSrc}, 16'b10_00_10_0_0);
      chk("lw_immsrc", {14'h0, immSrc}, 16'h0);
      tick();
      chk("lw_c2_state", {12'h0, state}, 16'h1);
      chk("lw_c2_strobes", {12'h0, strobes()}, 16'h0);
      chk("lw_c2_sel", {12'h0, aluSrcA, aluSrcB}, 16'b0101);
      tick();
      chk("lw_c3_state", {12'h0, state}, 16'h2);
      chk("lw_c3_sel", {12'h0, aluSrcA, aluSrcB}, 16'b1001);
      tick();
      chk("lw_c4_state", {12'h0, state}, 16'h3);
      chk("lw_c4_adr", {14'h0, adrSrc, resultSrc[0]}, 16'b10);
      chk("lw_c4_strobes", {12'h0, strobes()}, 16'h0);
      tick();
      chk("lw_c5_state", {12'h0, state}, 16'h4);
      chk("lw_c5_strobes", {12'h0, strobes()}, 16'b0010);
      chk("lw_c5_result", {14'h0, resultSrc}, 16'b01);
      tick();
      chk("lw_c6_state", {12'h0, state}, 16'h0);

      // sub: R-type, funct7b5=1
      op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
      tick();
      chk("sub_decode", {12'h0, state}, 16'h1);
      tick();
      chk("sub_exec_state", {12'h0, state}, 16'h6);
      chk("sub_aluctl", {13'h0, aluControl}, 16'b001);
      chk("sub_exec_sel", {12'h0, aluSrcA, aluSrcB}, 16'b1000);
      tick();
      chk("sub_aluwb_state", {12'h0, state}, 16'h8);
      chk("sub_aluwb_strobes", {12'h0, strobes()}, 16'b0010);
      tick();
      chk("sub_back_fetch", {12'h0, state}, 16'h0);

      // add: funct7b5=0; then slt/or/and variants in the same EXECUTER cycle
      funct7b5 = 1'b0;
      tick(); tick();
      chk("add_aluctl", {13'h0, aluControl}, 16'b000);
      funct3 = 3'b010; #1;
      chk("slt_aluctl", {13'h0, aluControl}, 16'b101);
      funct3 = 3'b110; #1;
      chk("or_aluctl", {13'h0, aluControl}, 16'b011);
      funct3 = 3'b111; #1;
      chk("and_aluctl", {13'h0, aluControl}, 16'b010);
      funct3 = 3'b001; #1;
      chk("other_aluctl", {13'h0, aluControl}, 16'b000);
      tick(); tick();
      chk("add_back_fetch", {12'h0, state}, 16'h0);

      // addi with funct7b5=1: op[5]=0 so still add
      op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1;
      tick(); tick();
      chk("addi_state", {12'h0, state}, 16'h7);
      chk("addi_aluctl", {13'h0, aluControl}, 16'b000);
      chk("addi_sel", {12'h0, aluSrcA, aluSrcB}, 16'b1001);
      tick(); tick();
      funct7b5 = 1'b0;

      // beq taken / not taken within BEQ cycle
      op = 7'b1100011; zero = 1'b1; #1;
      chk("beq_immsrc", {14'h0, immSrc}, 16'b10);
      tick(); tick();
      chk("beq_state", {12'h0, state}, 16'h9);
      chk("beq_pcwrite_z1", {15'h0, pcWrite}, 16'h1);
      chk("beq_aluctl", {13'h0, aluControl}, 16'b001);
      zero = 1'b0; #1;
      chk("beq_pcwrite_z0", {15'h0, pcWrite}, 16'h0);
      tick();
      chk("beq_back_fetch", {12'h0, state}, 16'h0);

      // jal: 0,1,10,8,0
      op = 7'b1101111; #1;
      chk("jal_immsrc", {14'h0, immSrc}, 16'b11);
      tick(); tick();
      chk("jal_state", {12'h0, state}, 16'hA);
      chk("jal_strobes", {12'h0, strobes()}, 16'b1000);
      chk("jal_sel", {12'h0, aluSrcA, aluSrcB}, 16'b0110);
      tick();
      chk("jal_aluwb", {12'h0, state}, 16'h8);
      tick();

      // fetch stall: memReady low 2 cycles; no-handshake instance advances
      op = 7'b0100011; memReady = 1'b0; #1;
      chk("stall_immsrc", {14'h0, immSrc}, 16'b01);
      chk("stall_c1_strobes", {12'h0, strobes()}, 16'h0);
      chk("nohs_c1_irwrite", {14'h0, irWrite2, pcWrite2}, 16'b11);
      tick();
      chk("stall_c2_state", {12'h0, state}, 16'h0);
      chk("nohs_c2_state", {12'h0, state2}, 16'h1);
      chk("stall_c2_strobes", {12'h0, strobes()}, 16'h0);
      tick();
      chk("stall_c3_state", {12'h0, state}, 16'h0);
      memReady = 1'b1; #1;
      chk("stall_c3_strobes", {12'h0, strobes()}, 16'b1100);
      tick();
      chk("stall_decode", {12'h0, state}, 16'h1);

      // illegal opcode from DECODE
      op = 7'b0000000;
      tick();
      chk("err_state", {12'h0, state}, 16'hB);
      chk("err_illegal", {15'h0, illegal}, 16'h1);
      for (int i = 0; i < 10; i++) begin
         memReady = i[0]; zero = ~i[0];
         tick();
         chk("err_hold_state", {12'h0, state}, 16'hB);
         chk("err_hold_out", {2'b0, strobes(), adrSrc, resultSrc, aluSrcA, aluSrcB,
                              aluControl}, 16'h0);
      end
      memReady = 1'b1;
      rst = 1'b1; #1;
      chk("err_rst_illegal", {15'h0, illegal}, 16'h0);
      tick();
      chk("err_rst_state", {12'h0, state}, 16'h0);
      rst = 1'b0; #1;

      // sw: store completes on memReady
      op = 7'b0100011;
      tick(); tick();
      memReady = 1'b0;
      tick();
      chk("sw_state", {12'h0, state}, 16'h5);
      chk("sw_strobes", {12'h0, strobes()}, 16'b0001);
      chk("sw_adr", {15'h0, adrSrc}, 16'h1);
      tick();
      chk("sw_wait_state", {12'h0, state}, 16'h5);
      chk("sw_wait_memwrite", {15'h0, memWrite}, 16'h1);
      memReady = 1'b1;
      tick();
      chk("sw_done_state", {12'h0, state}, 16'h0);

      // sw with memory never ready, reset during MEMWRITE
      tick(); tick();
      memReady = 1'b0;
      tick(); tick();
      chk("swrst_state", {12'h0, state}, 16'h5);
      rst = 1'b1; #1;
      chk("swrst_memwrite", {12'h0, strobes()}, 16'h0);
      tick();
      chk("swrst_state_after", {12'h0, state}, 16'h0);
      chk("swrst_strobes_after", {12'h0, strobes()}, 16'h0);
      rst = 1'b0;
      #1;
      chk("swrst_fetch_stall", {12'h0, strobes()}, 16'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
